// File: rtl/lock_ctrl_pkg.sv
// Shared types and defaults for the combination-lock session controller.
package lock_ctrl_pkg;

    localparam int SYM_W = 2;
    localparam logic [SYM_W-1:0] DEF_OPEN_Q   = 2'b11;
    localparam logic [SYM_W-1:0] DEF_IDLE_SYM = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_CHECK,
        S_LOCKOUT
    } state_t;

    function automatic int fail_w(input int max_fail);
        return $clog2(max_fail + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after the pointer wins; the
// pointer moves past the served index when adv is strobed.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             adv,
    input  logic [IDX_W-1:0] adv_idx,
    output logic [NREQ-1:0]  win,
    output logic [IDX_W-1:0] win_idx
);

    logic [IDX_W-1:0] ptr;

    always_comb begin
        logic [IDX_W-1:0] j;
        logic             found;
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        j       = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = IDX_W'((int'(ptr) + k) % NREQ);
            if (!found && req[j]) begin
                found   = 1'b1;
                win[j]  = 1'b1;
                win_idx = j;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (adv)
            ptr <= (adv_idx == IDX_W'(NREQ - 1)) ? '0 : adv_idx + 1'b1;
    end

endmodule

// File: rtl/lock_session_ctrl.sv
// Shares one combination lock between NREQ keypads: grant, clear, stream
// symbols, check the result, and lock everyone out after repeated failures.
module lock_session_ctrl
    import lock_ctrl_pkg::*;
#(
    parameter int               NREQ        = 2,
    parameter logic [SYM_W-1:0] OPEN_Q      = DEF_OPEN_Q,
    parameter logic [SYM_W-1:0] IDLE_SYM    = DEF_IDLE_SYM,
    parameter int               MAX_FAIL    = 3,
    parameter int               LOCKOUT_CYC = 16,
    parameter int               TIMEOUT     = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ-1:0]             sym_valid,
    input  logic [SYM_W*NREQ-1:0]       sym,
    input  logic [NREQ-1:0]             sym_last,
    output logic [NREQ-1:0]             gnt,
    output logic [NREQ-1:0]             sym_ready,
    output logic [SYM_W-1:0]            lock_s,
    output logic                        lock_rst,
    input  logic [SYM_W-1:0]            lock_q,
    output logic                        done,
    output logic                        pass,
    output logic                        locked_out,
    output logic [fail_w(MAX_FAIL)-1:0] fail_cnt
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int FC_W  = fail_w(MAX_FAIL);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int LO_W  = $clog2(LOCKOUT_CYC + 1);

    state_t                     state, state_nxt;
    logic [NREQ-1:0][SYM_W-1:0] sym_v;
    logic [NREQ-1:0]            win;
    logic [IDX_W-1:0]           win_idx, gidx, gidx_nxt;
    logic [TO_W-1:0]            to_cnt, to_nxt;
    logic [LO_W-1:0]            lo_cnt, lo_cnt_nxt;
    logic [NREQ-1:0]            gnt_nxt, rdy_nxt;
    logic [SYM_W-1:0]           lock_s_nxt;
    logic                       lock_rst_nxt, done_nxt, pass_nxt, lo_nxt;
    logic [FC_W-1:0]            fcnt_nxt;
    logic                       adv, finish, fail;

    assign sym_v = sym;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .adv     (adv),
        .adv_idx (gidx),
        .win     (win),
        .win_idx (win_idx)
    );

    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        rdy_nxt      = sym_ready;
        lock_s_nxt   = IDLE_SYM;
        lock_rst_nxt = 1'b0;
        done_nxt     = 1'b0;
        pass_nxt     = 1'b0;
        lo_nxt       = locked_out;
        fcnt_nxt     = fail_cnt;
        to_nxt       = to_cnt;
        lo_cnt_nxt   = lo_cnt;
        gidx_nxt     = gidx;
        adv          = 1'b0;
        finish       = 1'b0;
        fail         = 1'b0;

        case (state)
            S_IDLE: begin
                if (|req) begin
                    state_nxt    = S_CLEAR;
                    gnt_nxt      = win;
                    gidx_nxt     = win_idx;
                    lock_rst_nxt = 1'b1;
                end
            end
            S_CLEAR: begin
                state_nxt = S_STREAM;
                rdy_nxt   = gnt;
                to_nxt    = '0;
            end
            S_STREAM: begin
                if (!req[gidx]) begin
                    finish = 1'b1;
                    fail   = 1'b1;
                end else if (sym_valid[gidx] && sym_ready[gidx]) begin
                    lock_s_nxt = sym_v[gidx];
                    to_nxt     = '0;
                    if (sym_last[gidx]) begin
                        state_nxt = S_DRAIN;
                        rdy_nxt   = '0;
                    end
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    finish = 1'b1;
                    fail   = 1'b1;
                end else begin
                    to_nxt = to_cnt + 1'b1;
                end
            end
            // Lock registers the last symbol during this cycle.
            S_DRAIN: state_nxt = S_CHECK;
            S_CHECK: begin
                finish = 1'b1;
                fail   = (lock_q != OPEN_Q);
            end
            S_LOCKOUT: begin
                if (lo_cnt == LO_W'(LOCKOUT_CYC - 1)) begin
                    state_nxt = S_IDLE;
                    lo_nxt    = 1'b0;
                    fcnt_nxt  = '0;
                end else begin
                    lo_cnt_nxt = lo_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Session end, whether by check or abort.
        if (finish) begin
            done_nxt  = 1'b1;
            pass_nxt  = !fail;
            gnt_nxt   = '0;
            rdy_nxt   = '0;
            adv       = 1'b1;
            state_nxt = S_IDLE;
            if (!fail) begin
                fcnt_nxt = '0;
            end else if (fail_cnt >= FC_W'(MAX_FAIL - 1)) begin
                fcnt_nxt   = FC_W'(MAX_FAIL);
                state_nxt  = S_LOCKOUT;
                lo_nxt     = 1'b1;
                lo_cnt_nxt = '0;
            end else begin
                fcnt_nxt = fail_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            gnt        <= '0;
            sym_ready  <= '0;
            lock_s     <= IDLE_SYM;
            lock_rst   <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            locked_out <= 1'b0;
            fail_cnt   <= '0;
            to_cnt     <= '0;
            lo_cnt     <= '0;
            gidx       <= '0;
        end else begin
            state      <= state_nxt;
            gnt        <= gnt_nxt;
            sym_ready  <= rdy_nxt;
            lock_s     <= lock_s_nxt;
            lock_rst   <= lock_rst_nxt;
            done       <= done_nxt;
            pass       <= pass_nxt;
            locked_out <= lo_nxt;
            fail_cnt   <= fcnt_nxt;
            to_cnt     <= to_nxt;
            lo_cnt     <= lo_cnt_nxt;
            gidx       <= gidx_nxt;
        end
    end

endmodule

// File: tb/tb_lock_session_ctrl.sv
// Directed scenarios against a behavioural lock that opens on 01,11,01.
module tb_lock_session_ctrl;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req;
    logic [1:0]      sym_valid;
    logic [1:0][1:0] sym_a;
    logic [1:0]      sym_last;
    logic [1:0]      gnt;
    logic [1:0]      sym_ready;
    logic [1:0]      lock_s;
    logic            lock_rst;
    logic [1:0]      lock_q;
    logic            done;
    logic            pass;
    logic            locked_out;
    logic [1:0]      fail_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lock_session_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .sym_valid  (sym_valid),
        .sym        (sym_a),
        .sym_last   (sym_last),
        .gnt        (gnt),
        .sym_ready  (sym_ready),
        .lock_s     (lock_s),
        .lock_rst   (lock_rst),
        .lock_q     (lock_q),
        .done       (done),
        .pass       (pass),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt)
    );

    // Lock: progress 0..3 on the exact sequence, 4 = spoiled.
    logic [2:0] prog;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) prog <= 3'd0;
        else if (lock_rst) prog <= 3'd0;
        else if (lock_s != 2'b00) begin
            case (prog)
                3'd0:    prog <= (lock_s == 2'b01) ? 3'd1 : 3'd4;
                3'd1:    prog <= (lock_s == 2'b11) ? 3'd2 : 3'd4;
                3'd2:    prog <= (lock_s == 2'b01) ? 3'd3 : 3'd4;
                default: prog <= 3'd4;
            endcase
        end
    end
    assign lock_q = (prog == 3'd3) ? 2'b11 : 2'b00;

    task automatic wait_ready(input logic r, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sym_ready[r]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send(input logic r, input logic [1:0] s, input logic last);
        sym_valid[r] = 1'b1;
        sym_a[r]     = s;
        sym_last[r]  = last;
        @(negedge clk);
        sym_valid[r] = 1'b0;
        sym_a[r]     = 2'b00;
        sym_last[r]  = 1'b0;
    endtask

    task automatic wait_done(output bit ok, output logic p);
        ok = 1'b0;
        p  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ok = 1'b1;
                p  = pass;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = '0; sym_valid = '0; sym_a = '0; sym_last = '0;
        repeat (3) @(negedge clk);
        checks++; if ({gnt, sym_ready} !== 4'b0000) begin errors++; $display("FAIL reset_gnt_rdy got %b exp 0000", {gnt, sym_ready}); end
        checks++; if (lock_s !== 2'b00) begin errors++; $display("FAIL reset_lock_s got %b exp 00", lock_s); end
        checks++; if (lock_rst !== 1'b1) begin errors++; $display("FAIL reset_lock_rst got %b exp 1", lock_rst); end
        checks++; if ({done, pass, locked_out, fail_cnt} !== 5'b0) begin errors++; $display("FAIL reset_status got %b exp 00000", {done, pass, locked_out, fail_cnt}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_pass;
        bit ok; logic p;
        req = 2'b01;
        @(negedge clk);
        checks++; if ({gnt, lock_rst} !== 3'b011) begin errors++; $display("FAIL pass_grant got %b exp 011", {gnt, lock_rst}); end
        @(negedge clk);
        checks++; if ({sym_ready, lock_rst} !== 3'b010) begin errors++; $display("FAIL pass_stream got %b exp 010", {sym_ready, lock_rst}); end
        send(1'b0, 2'b01, 1'b0);
        checks++; if (lock_s !== 2'b01) begin errors++; $display("FAIL pass_lock_s got %b exp 01", lock_s); end
        send(1'b0, 2'b11, 1'b0);
        send(1'b0, 2'b01, 1'b1);
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL pass_latency done early got %b exp 0", done); end
        @(negedge clk);
        wait_done(ok, p);
        checks++; if (!ok || p !== 1'b1) begin errors++; $display("FAIL pass_result done %0d pass %b exp 1 1", ok, p); end
        checks++; if ({gnt, fail_cnt} !== 4'b0000) begin errors++; $display("FAIL pass_after got %b exp 0000", {gnt, fail_cnt}); end
        req = 2'b00;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL pass_done_pulse got %b exp 0", done); end
    endtask

    task automatic test_three_fails;
        bit ok; logic p; int cnt; bit bad;
        for (int f = 1; f <= 3; f++) begin
            req = 2'b10;
            wait_ready(1'b1, ok);
            send(1'b1, 2'b10, 1'b0);
            send(1'b1, 2'b10, 1'b1);
            wait_done(ok, p);
            req = 2'b00;
            checks++; if (!ok || p !== 1'b0 || fail_cnt !== 2'(f)) begin
                errors++; $display("FAIL fails_%0d done %0d pass %b cnt %0d exp 1 0 %0d", f, ok, p, fail_cnt, f);
            end
            if (f < 3) @(negedge clk);
        end
        checks++; if (locked_out !== 1'b1) begin errors++; $display("FAIL lockout_enter got %b exp 1", locked_out); end
        req = 2'b01;
        cnt = 0; bad = 1'b0;
        while (locked_out && cnt < 40) begin
            cnt++;
            if (gnt !== 2'b00) bad = 1'b1;
            @(negedge clk);
        end
        checks++; if (cnt !== 16) begin errors++; $display("FAIL lockout_len got %0d exp 16", cnt); end
        checks++; if (bad) begin errors++; $display("FAIL lockout_grant got 1 exp 0"); end
        checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL lockout_clear got %0d exp 0", fail_cnt); end
        req = 2'b00;
        @(negedge clk);
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL post_lockout_gnt got %b exp 00", gnt); end
    endtask

    task automatic test_rr;
        bit ok; logic p; int i;
        req = 2'b11;
        i = 0;
        do begin @(negedge clk); i++; end while (gnt == 2'b00 && i < 20);
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rr_first got %b exp 01", gnt); end
        wait_ready(1'b0, ok);
        send(1'b0, 2'b01, 1'b0); send(1'b0, 2'b11, 1'b0); send(1'b0, 2'b01, 1'b1);
        wait_done(ok, p);
        checks++; if (!ok || p !== 1'b1) begin errors++; $display("FAIL rr_first_pass done %0d pass %b exp 1 1", ok, p); end
        @(negedge clk);
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rr_second got %b exp 10", gnt); end
        wait_ready(1'b1, ok);
        send(1'b1, 2'b01, 1'b0); send(1'b1, 2'b11, 1'b0); send(1'b1, 2'b01, 1'b1);
        wait_done(ok, p);
        req = 2'b00;
        checks++; if (!ok || p !== 1'b1) begin errors++; $display("FAIL rr_second_pass done %0d pass %b exp 1 1", ok, p); end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        bit ok; int n; bit sbad;
        req = 2'b01;
        wait_ready(1'b0, ok);
        n = 0; sbad = (lock_s !== 2'b00);
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (lock_s !== 2'b00) sbad = 1'b1;
            if (done) break;
        end
        checks++; if (n !== 8 || done !== 1'b1) begin errors++; $display("FAIL timeout_len got %0d done %b exp 8 1", n, done); end
        checks++; if (pass !== 1'b0 || fail_cnt !== 2'd1) begin errors++; $display("FAIL timeout_result pass %b cnt %0d exp 0 1", pass, fail_cnt); end
        checks++; if (sbad) begin errors++; $display("FAIL timeout_lock_s got nonidle exp 00"); end
        req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_abort;
        bit ok;
        req = 2'b10;
        wait_ready(1'b1, ok);
        send(1'b1, 2'b01, 1'b0);
        req = 2'b00;
        @(negedge clk);
        checks++; if ({done, pass, fail_cnt} !== 4'b1010) begin errors++; $display("FAIL abort_result got %b exp 1010", {done, pass, fail_cnt}); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit ok; bit dbad;
        req = 2'b01;
        wait_ready(1'b0, ok);
        send(1'b0, 2'b01, 1'b0);
        checks++; if (lock_s !== 2'b01) begin errors++; $display("FAIL mid_pre_lock_s got %b exp 01", lock_s); end
        rst_n = 1'b0;
        #1;
        checks++; if ({gnt, sym_ready, lock_s, lock_rst} !== 7'b0000001) begin errors++; $display("FAIL mid_reset_ctrl got %b exp 0000001", {gnt, sym_ready, lock_s, lock_rst}); end
        checks++; if ({done, pass, locked_out, fail_cnt} !== 5'b0) begin errors++; $display("FAIL mid_reset_status got %b exp 00000", {done, pass, locked_out, fail_cnt}); end
        @(negedge clk);
        req = 2'b00;
        rst_n = 1'b1;
        dbad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || gnt !== 2'b00) dbad = 1'b1;
        end
        checks++; if (dbad) begin errors++; $display("FAIL mid_no_done got activity exp none"); end
    endtask

    initial begin
        test_reset;
        test_single_pass;
        test_three_fails;
        test_rr;
        test_timeout;
        test_abort;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_session_ctrl.md
Name: lock_session_ctrl

Overview:
- Round-robin controller that shares one combination-lock FSM between NREQ keypad requesters.
- Per session:
  - grants one requester;
  - clears the lock;
  - streams that requester's 2-bit symbols into the lock, one per accepted beat;
  - samples the lock state and reports pass or fail.
- Counts consecutive failures and imposes a timed lockout.
- Sits between the keypad front-ends and the lock instance, and owns the lock's s input and reset.

Parameters:
- NREQ, 2, number of requesters (2..4).
- OPEN_Q, 2'b11, lock state value that means "open".
- IDLE_SYM, 2'b00, value driven on lock_s when no symbol is being applied.
- MAX_FAIL, 3, consecutive failed sessions that trigger lockout.
- LOCKOUT_CYC, 16, lockout duration in clk cycles.
- TIMEOUT, 8, maximum idle cycles between symbols within a session.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester session request, level.
- sym_valid  in  NREQ  per-requester symbol valid.
- sym  in  2*NREQ  per-requester symbol; requester i uses bits [2i+1:2i].
- sym_last  in  NREQ  marks the final symbol of a session.
- gnt  out  NREQ  one-hot grant, registered.
- sym_ready  out  NREQ  symbol accept, asserted only for the granted requester in STREAM.
- lock_s  out  2  registered drive to the lock's s input.
- lock_rst  out  1  registered active-high reset to the lock.
- lock_q  in  2  lock state Q.
- done  out  1  one-cycle session-complete pulse.
- pass  out  1  result; valid only while done=1.
- locked_out  out  1  high during lockout.
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive fail count.

Behaviour:
- Reset values (rst_n=0, asynchronous):
  - gnt=0, sym_ready=0, lock_s=IDLE_SYM, lock_rst=1, done=0, pass=0, locked_out=0, fail_cnt=0.
  - State IDLE; RR pointer at requester 0; counters 0.
  - Reset mid-session aborts the session with no done pulse.
- States: IDLE, CLEAR, STREAM, DRAIN, CHECK, LOCKOUT.
- IDLE:
  - lock_rst=0, lock_s=IDLE_SYM.
  - If any req is high, pick the first requesting index at or after the RR pointer.
  - Next cycle: gnt is one-hot for the winner; go to CLEAR.
- CLEAR:
  - Lasts exactly 1 cycle with lock_rst=1; then go to STREAM.
  - The timeout counter is reset here.
- STREAM:
  - sym_ready[g]=1 for the granted requester g.
  - On sym_valid[g]&sym_ready[g], lock_s takes sym[g] for exactly the next cycle; otherwise lock_s=IDLE_SYM.
  - Each accepted symbol resets the timeout counter.
  - Accepted symbol with sym_last → DRAIN.
  - req[g] falling before sym_last → abort as a fail (done=1, pass=0).
  - TIMEOUT consecutive cycles without a symbol → same abort.
- DRAIN: 1 cycle, covering the lock's register latency; sym_ready=0.
- CHECK:
  - Sample lock_q: pass = (lock_q==OPEN_Q). Pulse done for one cycle; drop gnt.
  - Advance the RR pointer to g+1 (mod NREQ).
- Fail accounting:
  - pass clears fail_cnt.
  - A fail increments fail_cnt, saturating at MAX_FAIL.
  - If fail_cnt reaches MAX_FAIL, go to LOCKOUT; otherwise go to IDLE.
- LOCKOUT:
  - locked_out=1; no grants; requests ignored.
  - After LOCKOUT_CYC cycles: fail_cnt=0, locked_out=0, go to IDLE.
- Latency: acceptance of the last symbol at edge k gives done high in the cycle after edge k+2.
- Requesters must hold req until done; a req held after done does not regain the grant while others are requesting (round robin).
- Simultaneous req from all requesters: strict RR order, no starvation.
- All outputs registered; no combinational path from inputs to lock_s.

Decomposition:
- Package lock_ctrl_pkg:
  - state enum;
  - SYM_W=2;
  - default OPEN_Q and IDLE_SYM constants;
  - fail-count width function.
- Sub-module rr_arbiter:
  - NREQ-wide request vector in, one-hot grant out;
  - pointer update on an advance strobe.
- Top holds the FSM, timeout counter, lockout counter and fail counter.

Test Plan:
- Bench lock model: opens (lock_q=2'b11) iff the symbols applied after lock_rst are exactly 01,11,01 with no non-idle symbol in between.
- Single pass: req[0], stream 01,11,01(last) → gnt=01, lock_rst one cycle, done with pass=1, fail_cnt=0.
- Three fails: req[1] sends 10,10(last), repeated 3× → fail_cnt 1,2,3; locked_out=1 for 16 cycles; then fail_cnt=0 and IDLE.
- RR contention: req=2'b11 held for two sessions → first gnt=01, second gnt=10.
- Timeout: after grant, no sym_valid for 8 cycles → done=1, pass=0, lock_s stays 00 throughout.
- Abort and reset: drop req mid-stream → fail reported. Separately, rst_n low mid-STREAM → all outputs at reset values immediately, no done pulse.
